sdram_fb_ctrl: RTL and testbench
================================

SDRAM_FB_CTRL -- requirements
Module: sdram_fb_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 24, SDRAM word address width; LEN_W, default 10, burst length width; LVL_W, default 10, FIFO level width; PINGPONG, default 1, 1 = two-frame ping-pong, 0 = single buffer; PP_OFFSET, default 24'h40_0000, address offset of frame buffer 1; ARB_RR, default 0, 0 = write priority, 1 = round robin.
REQ-002 One clock; reset is asynchronous and active-low (sys_clk, sys_rst_n).
REQ-003 Ports SHALL be:
sys_clk  in  1  system clock
sys_rst_n  in  1  async active-low reset
init_end  in  1  SDRAM initialisation complete
wr_rst / rd_rst  in  1 each  sync write/read pointer reload
read_valid  in  1  read path enable
wr_fifo_num / rd_fifo_num  in  LVL_W each  write-FIFO read-side level / read-FIFO write-side level
wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr  in  ADDR_W each  frame begin/end addresses
wr_burst_len / rd_burst_len  in  LEN_W each  burst lengths, nonzero
sdram_wr_ack / sdram_rd_ack  in  1 each  controller burst-active acks
sdram_wr_req / sdram_rd_req  out  1 each  burst requests
sdram_wr_addr / sdram_rd_addr  out  ADDR_W each  burst start addresses
wr_frame_done / rd_frame_done  out  1 each  one-cycle frame-wrap pulses
wr_buf / rd_buf  out  1 each  active buffer index

Function
REQ-004 FSM states SHALL be IDLE, WR, RD; the FSM leaves IDLE only while init_end=1.
REQ-005 wr_need SHALL be (wr_fifo_num >= wr_burst_len), zero-extended compare; rd_need SHALL be (read_valid=1 and rd_fifo_num < rd_burst_len).
REQ-006 In IDLE, with ARB_RR=0: wr_need wins over rd_need. With ARB_RR=1 and both needs set, the grant SHALL go to the type not granted last; last_grant resets to RD.
REQ-007 Grant SHALL register next cycle: state WR/RD, matching req=1; req SHALL stay 1 until the matching ack is sampled 1, then drop the following cycle.
REQ-008 Burst end SHALL be the ack falling edge (registered ack=1, current ack=0); FSM returns to IDLE that cycle; no new request is asserted in the same cycle.
REQ-009 Pointer advance at write burst end: if wr_ptr < wr_e_addr - wr_burst_len then wr_ptr += wr_burst_len, else wr_ptr <= wr_b_addr and wrap event; reads identical with rd_* signals.
REQ-010 sdram_wr_addr SHALL equal wr_ptr + (wr_buf ? PP_OFFSET : 0), registered; sdram_rd_addr likewise with rd_ptr/rd_buf; modulo 2^ADDR_W.
REQ-011 Write wrap SHALL pulse wr_frame_done, set frame_ready, record last_done = wr_buf, and with PINGPONG=1 toggle wr_buf unless ~wr_buf == rd_buf (then wr_buf holds, buffer rewritten).
REQ-012 Read wrap SHALL pulse rd_frame_done; with PINGPONG=1 and frame_ready=1, rd_buf <= last_done and frame_ready clears; otherwise rd_buf holds (frame repeated).
REQ-013 Write wrap and read wrap in the same cycle SHALL evaluate REQ-012 using pre-update last_done/frame_ready, then apply REQ-011 against the new rd_buf.
REQ-014 PINGPONG=0: wr_buf, rd_buf SHALL stay 0; frame_ready unused.
REQ-015 wr_rst=1 SHALL load wr_ptr <= wr_b_addr, wr_buf <= 0, clear frame_ready, overriding REQ-009/011 that cycle; rd_rst=1 SHALL load rd_ptr <= rd_b_addr, rd_buf <= 0. An in-flight burst SHALL complete without advancing the reset pointer.
REQ-016 init_end falling SHALL force IDLE and both req to 0 next cycle; pointers and buffers hold.
REQ-017 Ack edges arriving in the wrong state SHALL be ignored for pointer update.

Reset
REQ-018 On sys_rst_n=0: state IDLE, all req/pulse outputs 0, pointers 0, addresses 0, wr_buf=rd_buf=0, frame_ready=0, last_grant=RD, ack delay registers 0.

Verification
REQ-019 init_end=1, wr_fifo_num=512, wr_burst_len=512, rd_need=1, ARB_RR=0 -> sdram_wr_req=1 next cycle, rd_req=0; after ack high 512 cycles then low, sdram_wr_addr=wr_b_addr+512.
REQ-020 ARB_RR=1, both needs held, 4 bursts -> grant sequence WR,RD,WR,RD.
REQ-021 wr_b=0, wr_e=1024, len=512: two bursts -> wrap, wr_frame_done one pulse, wr_buf=1, sdram_wr_addr=0x40_0000.
REQ-022 Reader on buf 0, writer completes frames on buf 1 then again -> second wrap holds wr_buf=1 (no toggle into buf 0); reader wrap switches rd_buf=1.
REQ-023 wr_rst asserted mid-burst -> burst finishes, wr_ptr=wr_b_addr, wr_buf=0, no advance.
REQ-024 sys_rst_n low during RD with req=1 -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/sdram_fb_ctrl.sv
// sdram_fb_ctrl: arbitrates write/read frame-buffer bursts to an SDRAM controller
// and walks ping-pong frame pointers with buffer hand-off between writer and reader.
module sdram_fb_ctrl #(
  parameter int                ADDR_W    = 24,
  parameter int                LEN_W     = 10,
  parameter int                LVL_W     = 10,
  parameter int                PINGPONG  = 1,
  parameter logic [ADDR_W-1:0] PP_OFFSET = ADDR_W'(24'h40_0000),
  parameter int                ARB_RR    = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic              wr_rst,
  input  logic              rd_rst,
  input  logic              read_valid,
  input  logic [LVL_W-1:0]  wr_fifo_num,
  input  logic [LVL_W-1:0]  rd_fifo_num,
  input  logic [ADDR_W-1:0] wr_b_addr,
  input  logic [ADDR_W-1:0] wr_e_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic [ADDR_W-1:0] rd_e_addr,
  input  logic [LEN_W-1:0]  wr_burst_len,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic              wr_buf,
  output logic              rd_buf
);
  localparam int CW = (LVL_W > LEN_W) ? LVL_W : LEN_W;
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t state, nxt;
  logic wr_ack_d, rd_ack_d, last_wr, frame_ready, last_done, wr_skip, rd_skip;
  logic wr_need, rd_need, grant_wr, grant_rd;
  logic wr_end, rd_end, wr_adv, rd_adv, wr_wrap, rd_wrap, rd_buf_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_len, rd_len;
  assign wr_len    = ADDR_W'(wr_burst_len);
  assign rd_len    = ADDR_W'(rd_burst_len);
  assign wr_need   = CW'(wr_fifo_num) >= CW'(wr_burst_len);
  assign rd_need   = read_valid && (CW'(rd_fifo_num) < CW'(rd_burst_len));
  assign wr_end    = (state == WR) && wr_ack_d && !sdram_wr_ack;
  assign rd_end    = (state == RD) && rd_ack_d && !sdram_rd_ack;
  // a pointer reload during a burst suppresses that burst's advance
  assign wr_adv    = wr_end && !wr_rst && !wr_skip;
  assign rd_adv    = rd_end && !rd_rst && !rd_skip;
  assign wr_wrap   = wr_adv && !(wr_ptr < wr_e_addr - wr_len);
  assign rd_wrap   = rd_adv && !(rd_ptr < rd_e_addr - rd_len);
  assign rd_buf_nx = rd_rst ? 1'b0 :
                     (rd_wrap && PINGPONG != 0 && frame_ready) ? last_done : rd_buf;
  always_comb begin
    grant_wr = wr_need && (!rd_need || ARB_RR == 0 || !last_wr);
    grant_rd = rd_need && !grant_wr;
    nxt      = state;
    if (!init_end)
      nxt = IDLE;
    else if (state == IDLE)
      nxt = grant_wr ? WR : grant_rd ? RD : IDLE;
    else if (wr_end || rd_end)
      nxt = IDLE;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else            state <= nxt;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ack_d      <= 1'b0;
      rd_ack_d      <= 1'b0;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_rd_addr <= '0;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
      wr_buf        <= 1'b0;
      rd_buf        <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      last_wr       <= 1'b0;
      frame_ready   <= 1'b0;
      last_done     <= 1'b0;
      wr_skip       <= 1'b0;
      rd_skip       <= 1'b0;
    end else begin
      wr_ack_d      <= sdram_wr_ack;
      rd_ack_d      <= sdram_rd_ack;
      sdram_wr_req  <= !init_end ? 1'b0 : (state == IDLE && nxt == WR) ? 1'b1 :
                       sdram_wr_ack ? 1'b0 : sdram_wr_req;
      sdram_rd_req  <= !init_end ? 1'b0 : (state == IDLE && nxt == RD) ? 1'b1 :
                       sdram_rd_ack ? 1'b0 : sdram_rd_req;
      if (state == IDLE && nxt != IDLE)
        last_wr <= (nxt == WR);
      wr_skip       <= (state == WR) && (wr_rst || wr_skip);
      rd_skip       <= (state == RD) && (rd_rst || rd_skip);
      wr_ptr        <= (wr_rst || wr_wrap) ? wr_b_addr : wr_adv ? wr_ptr + wr_len : wr_ptr;
      rd_ptr        <= (rd_rst || rd_wrap) ? rd_b_addr : rd_adv ? rd_ptr + rd_len : rd_ptr;
      wr_frame_done <= wr_wrap;
      rd_frame_done <= rd_wrap;
      rd_buf        <= rd_buf_nx;
      // writer never toggles onto the buffer the reader is about to use
      wr_buf        <= wr_rst ? 1'b0 :
                       (wr_wrap && PINGPONG != 0 && (!wr_buf != rd_buf_nx)) ? !wr_buf : wr_buf;
      frame_ready   <= wr_rst ? 1'b0 : wr_wrap ? 1'b1 :
                       (rd_wrap && frame_ready) ? 1'b0 : frame_ready;
      if (wr_wrap)
        last_done <= wr_buf;
      sdram_wr_addr <= wr_ptr + (wr_buf ? PP_OFFSET : '0);
      sdram_rd_addr <= rd_ptr + (rd_buf ? PP_OFFSET : '0);
    end
  end
endmodule

// File: tb/tb_sdram_fb_ctrl.sv
// tb_sdram_fb_ctrl: directed checks of arbitration, pointer walk, ping-pong hand-off,
// pointer reload, init loss and async reset; second instance covers round-robin.
module tb_sdram_fb_ctrl;
  logic        sys_clk = 0, sys_rst_n = 0, init_end = 0, wr_rst = 0, rd_rst = 0, read_valid = 0;
  logic [9:0]  wr_fifo_num = 0, rd_fifo_num = 0, wr_burst_len = 10'd512, rd_burst_len = 10'd4;
  logic [23:0] wr_b_addr = 24'h0, wr_e_addr = 24'd1024, rd_b_addr = 24'h100, rd_e_addr = 24'h108;
  logic        wr_ack = 0, rd_ack = 0, rr_wr_ack = 0, rr_rd_ack = 0;
  logic        wr_req, rd_req, wr_done, rd_done, wr_buf, rd_buf;
  logic [23:0] wr_addr, rd_addr;
  logic        rr_wr_req, rr_rd_req, rr_wr_done, rr_rd_done, rr_wr_buf, rr_rd_buf;
  logic [23:0] rr_wr_addr, rr_rd_addr;
  int n_chk = 0, n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_fb_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end), .wr_rst(wr_rst), .rd_rst(rd_rst),
    .read_valid(read_valid), .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num),
    .wr_b_addr(wr_b_addr), .wr_e_addr(wr_e_addr), .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack), .sdram_wr_req(wr_req), .sdram_rd_req(rd_req),
    .sdram_wr_addr(wr_addr), .sdram_rd_addr(rd_addr), .wr_frame_done(wr_done), .rd_frame_done(rd_done),
    .wr_buf(wr_buf), .rd_buf(rd_buf));

  sdram_fb_ctrl #(.ARB_RR(1)) dut_rr (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end), .wr_rst(wr_rst), .rd_rst(rd_rst),
    .read_valid(read_valid), .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num),
    .wr_b_addr(wr_b_addr), .wr_e_addr(wr_e_addr), .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .sdram_wr_ack(rr_wr_ack), .sdram_rd_ack(rr_rd_ack), .sdram_wr_req(rr_wr_req), .sdram_rd_req(rr_rd_req),
    .sdram_wr_addr(rr_wr_addr), .sdram_rd_addr(rr_rd_addr), .wr_frame_done(rr_wr_done),
    .rd_frame_done(rr_rd_done), .wr_buf(rr_wr_buf), .rd_buf(rr_rd_buf));

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ack held n cycles then dropped; returns just after the burst-end edge
  task automatic burst(input bit w, input int n);
    if (w) wr_ack = 1; else rd_ack = 1;
    tick(n);
    wr_ack = 0;
    rd_ack = 0;
    tick(1);
  endtask

  initial begin
    #2;
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_buf", wr_buf, 0);
    chk("rst_rd_buf", rd_buf, 0);
    chk("rst_wr_done", wr_done, 0);
    tick(1);
    sys_rst_n = 1;
    wr_fifo_num = 10'd512;
    read_valid = 1;
    rd_rst = 1;
    tick(1);
    rd_rst = 0;
    tick(3);
    chk("no_init_wr_req", wr_req, 0);
    chk("rd_rst_addr", rd_addr, 24'h100);
    init_end = 1;
    tick(1);
    chk("prio_wr_req", wr_req, 1);
    chk("prio_rd_req", rd_req, 0);
    wr_ack = 1;
    tick(1);
    chk("req_drop_on_ack", wr_req, 0);
    tick(511);
    wr_ack = 0;
    tick(2);
    chk("wr_addr_512", wr_addr, 24'd512);
    chk("regrant_wr", wr_req, 1);
    chk("regrant_no_rd", rd_req, 0);
    burst(1, 4);
    chk("wrap_done_pulse", wr_done, 1);
    wr_fifo_num = 0;
    tick(1);
    chk("wrap_done_single", wr_done, 0);
    chk("wrap_wr_buf", wr_buf, 1);
    chk("wrap_wr_addr", wr_addr, 24'h40_0000);
    chk("grant_rd", rd_req, 1);
    burst(0, 4);
    wr_fifo_num = 10'd512;
    tick(1);
    chk("rd_addr_adv", rd_addr, 24'h104);
    chk("rd_buf_0", rd_buf, 0);
    chk("rd_no_done", rd_done, 0);
    chk("grant_wr2", wr_req, 1);
    burst(1, 4);
    tick(1);
    chk("wr_addr_b1", wr_addr, 24'h40_0200);
    burst(1, 4);
    chk("wrap2_done", wr_done, 1);
    wr_fifo_num = 0;
    tick(1);
    chk("wrap2_hold_buf", wr_buf, 1);
    chk("wrap2_wr_addr", wr_addr, 24'h40_0000);
    chk("grant_rd2", rd_req, 1);
    burst(0, 4);
    chk("rd_wrap_done", rd_done, 1);
    read_valid = 0;
    wr_fifo_num = 10'd512;
    tick(1);
    chk("rd_switch_buf", rd_buf, 1);
    chk("rd_switch_addr", rd_addr, 24'h40_0100);
    chk("grant_wr3", wr_req, 1);
    wr_ack = 1;
    tick(2);
    wr_rst = 1;
    tick(1);
    wr_rst = 0;
    tick(2);
    wr_ack = 0;
    tick(2);
    chk("wr_rst_addr", wr_addr, 24'h0);
    chk("wr_rst_buf", wr_buf, 0);
    chk("wr_rst_regrant", wr_req, 1);
    init_end = 0;
    tick(1);
    chk("init_loss_wr_req", wr_req, 0);
    chk("init_loss_rd_req", rd_req, 0);
    chk("init_loss_rd_buf", rd_buf, 1);
    wr_fifo_num = 0;
    read_valid = 1;
    init_end = 1;
    tick(1);
    chk("rd_req_before_rst", rd_req, 1);
    sys_rst_n = 0;
    #1;
    chk("arst_rd_req", rd_req, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_rd_buf", rd_buf, 0);
    init_end = 0;
    tick(1);
    sys_rst_n = 1;
    tick(2);
    chk("post_rst_idle", rd_req, 0);
    wr_fifo_num = 10'd512;
    read_valid = 1;
    init_end = 1;
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      while (!(rr_wr_req || rr_rd_req) && t < 20) begin
        tick(1);
        t++;
      end
      chk("rr_req_seen", rr_wr_req | rr_rd_req, 1);
      chk("rr_grant_is_wr", rr_wr_req, (i % 2 == 0) ? 1 : 0);
      if (rr_wr_req) rr_wr_ack = 1; else rr_rd_ack = 1;
      tick(3);
      rr_wr_ack = 0;
      rr_rd_ack = 0;
      tick(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
